ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
Parametrised multi-cycle RV32M/RV64M multiply/divide unit. It sits in the EX stage beside the single-cycle ALU and takes the already-forwarded operands (post forwarding-mux, pre immediate mux). An iterative datapath handles MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. It raises a stall request to the hazard unit while running and returns a registered result with a one-cycle done pulse.

Parameters:
XLEN, 32, operand/result width (32 or 64)
UNROLL, 1, product/quotient bits retired per cycle; must divide XLEN (1, 2, 4)

Ports:
clk  input  1  pipeline clock
reset  input  1  synchronous, active-high reset
start  input  1  EX holds a valid M-extension instruction (opcode OP, funct7 = 0000001)
funct3  input  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  XLEN  forwarded rs1 value
op_b  input  XLEN  forwarded rs2 value
flush  input  1  EX flush from branch/jump resolution; aborts the operation
stall_req  output  1  freezes IF/ID/EX; low when the result is ready
done  output  1  one-cycle pulse; result valid
result  output  XLEN  registered result, held until the next done

Behaviour:
- Reset: state=IDLE; done=0; result=0; all internal accumulators=0. Reset mid-operation acts as an abort.
- N = XLEN/UNROLL iterations.
- States:
  - IDLE: start=1 and flush=0 latch funct3 plus operand magnitudes and sign flags. Go to RUN. Special divides go to DONE instead.
  - RUN: retire UNROLL bits per cycle via shift-add (mul) or restoring subtract (div). After N cycles go to DONE.
  - DONE: done=1 for exactly one cycle with result valid. Then return to IDLE.
- Latency: start sampled at edge k. Normal ops give done in cycle k+N+1. Special divides give done in cycle k+1.
- stall_req = (IDLE and start and not flush) or RUN. stall_req is 0 in DONE, so the pipeline advances and captures result in that cycle.
- start is ignored in RUN and DONE. EX holds the instruction stable while stalled; op_a/op_b/funct3 are sampled only at acceptance.
- flush in any state: next state IDLE, no done, result unchanged. flush has priority over start.
- Multiply:
  - Unsigned magnitudes form a 2*XLEN product; the product is negated if the operand signs differ.
  - MUL returns the low XLEN bits. MULH/MULHSU/MULHU return the high XLEN bits.
  - Signedness: MULH treats both operands as signed. MULHSU treats op_a signed and op_b unsigned. MULHU treats both as unsigned.
- Divide:
  - Divide uses magnitudes. Quotient is negated if signs differ (DIV only). Remainder takes the sign of the dividend (REM only).
  - Divide by zero: quotient = all ones; remainder = op_a. Applies to signed and unsigned.
  - Signed overflow (op_a = most negative, op_b = -1): DIV returns op_a; REM returns 0.
  - Both special cases skip RUN.
- All arithmetic is modulo 2^XLEN for results. No exceptions are raised.

Decomposition:
- Shared package riscv_pkg:
  - funct3 M-op localparams.
  - FUNCT7_MULDIV constant.
  - muldiv_state_t enum {IDLE, RUN, DONE}.
  - XLEN default.
- One sub-module: muldiv_step, a combinational single-bit step (conditional add for mul, trial subtract for div). It is instantiated UNROLL times in a generate chain.

Test Plan:
1. MULH, op_a=0x80000000, op_b=0x80000000 (XLEN=32, UNROLL=1) -> stall_req high 33 cycles including the start cycle, done at cycle 33, result=0x40000000; MUL with the same operands -> 0x00000000.
2. DIV, op_a=0xFFFFFFF9 (-7), op_b=2 -> result 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
3. DIVU 0x12345678/0 -> 0xFFFFFFFF; REMU 7/0 -> 7. Both give done in cycle k+1, with stall_req high only in the start cycle.
4. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0, with 1-cycle latency.
5. Start MULHU 0xFFFFFFFF*0xFFFFFFFF, assert flush at cycle 10 -> IDLE next cycle, no done, result keeps its previous value. A new start next cycle gives 0xFFFFFFFE at done.
6. Run UNROLL=4, XLEN=64 with random operands vs a reference model -> done at k+17. Assert reset at cycle 5 of RUN -> done=0, result=0, state IDLE the next cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32M/RV64M definitions: M-op funct3 codes, funct7 tag,
// multiply/divide FSM states and the default datapath width.
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } muldiv_state_t;

    // funct3[2] separates the divide group from the multiply group
    function automatic logic f3_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational bit-step shared by multiply and divide.
// Ports: is_div selects trial-subtract (1) or conditional-add (0);
//   hi/lo are the working pair, m the multiplicand or divisor,
//   hi_nxt/lo_nxt the pair after one retired bit.
module muldiv_step
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] m,
    output logic [XLEN-1:0] hi_nxt,
    output logic [XLEN-1:0] lo_nxt
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shl;
    logic [XLEN+1:0] diff;
    logic            unused_top;

    // Multiply: hi accumulates, lo holds the multiplier and
    // collects product bits shifted in from the top.
    // Divide: hi is the partial remainder, lo shifts the dividend
    // out of its top and the quotient bits into its bottom.
    always_comb begin
        sum    = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
        shl    = {hi, lo[XLEN-1]};
        diff   = {1'b0, shl} - {2'b00, m};
        hi_nxt = '0;
        lo_nxt = '0;
        if (is_div) begin
            if (!diff[XLEN+1]) begin
                hi_nxt = diff[XLEN-1:0];
                lo_nxt = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_nxt = shl[XLEN-1:0];
                lo_nxt = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_nxt = sum[XLEN:1];
            lo_nxt = {sum[0], lo[XLEN-1:1]};
        end
    end

    // A successful subtract always leaves a value below m,
    // so this bit is zero whenever it would be selected.
    assign unused_top = diff[XLEN];

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the EX stage.
// Ports: clk, reset (sync, active high), start/funct3/op_a/op_b
//   from EX, flush abort; stall_req to hazard unit, done pulse,
//   registered result held until the next done.
module ex_muldiv_unit
    import riscv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int N  = XLEN / UNROLL;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [XLEN-1:0] MIN_NEG =
        {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t st, st_nxt;

    logic [2:0]      f3_q;
    logic [XLEN-1:0] hi_q, lo_q, m_q;
    logic            neg_q, neg_r;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] result_q;

    logic            accept, last;
    logic            signed_a, signed_b;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            is_div;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    logic [XLEN-1:0] hi_c [0:UNROLL];
    logic [XLEN-1:0] lo_c [0:UNROLL];

    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo, rem, fin;
    logic              sel_lo, sel_hi, sel_q, sel_r;

    // ---------------- operand decode at acceptance
    assign accept = start && !flush;
    assign is_div = f3_is_div(funct3);

    always_comb begin
        signed_a = (funct3 != F3_MULHU) &&
                   (funct3 != F3_DIVU) &&
                   (funct3 != F3_REMU);
        signed_b = signed_a && (funct3 != F3_MULHSU);
        a_neg    = signed_a && op_a[XLEN-1];
        b_neg    = signed_b && op_b[XLEN-1];
        a_mag    = a_neg ? -op_a : op_a;
        b_mag    = b_neg ? -op_b : op_b;
        div_zero = is_div && (op_b == '0);
        div_ovf  = is_div && !funct3[0] &&
                   (op_a == MIN_NEG) && (op_b == '1);
        special  = div_zero || div_ovf;
        // funct3[1] picks REM over DIV inside the divide group
        special_res = '0;
        if (div_zero)
            special_res = funct3[1] ? op_a : '1;
        else if (div_ovf)
            special_res = funct3[1] ? '0 : op_a;
    end

    // ---------------- step chain
    assign hi_c[0] = hi_q;
    assign lo_c[0] = lo_q;

    for (genvar i = 0; i < UNROLL; i++) begin : g_step
        muldiv_step #(
            .XLEN(XLEN)
        ) u_step (
            .is_div (f3_q[2]),
            .hi     (hi_c[i]),
            .lo     (lo_c[i]),
            .m      (m_q),
            .hi_nxt (hi_c[i+1]),
            .lo_nxt (lo_c[i+1])
        );
    end

    assign last = (cnt_q == CW'(N - 1));

    // ---------------- sign fix-up of the final iteration
    always_comb begin
        prod   = {hi_c[UNROLL], lo_c[UNROLL]};
        prod_s = neg_q ? -prod : prod;
        quo    = neg_q ? -lo_c[UNROLL] : lo_c[UNROLL];
        rem    = neg_r ? -hi_c[UNROLL] : hi_c[UNROLL];
        sel_lo = (f3_q == F3_MUL);
        sel_hi = !f3_q[2] && (f3_q[1:0] != 2'b00);
        sel_q  = f3_q[2] && !f3_q[1];
        sel_r  = f3_q[2] && f3_q[1];
        fin    = '0;
        unique case (1'b1)
            sel_lo:  fin = prod_s[XLEN-1:0];
            sel_hi:  fin = prod_s[2*XLEN-1:XLEN];
            sel_q:   fin = quo;
            sel_r:   fin = rem;
            default: fin = '0;
        endcase
    end

    // ---------------- FSM: state register
    always_ff @(posedge clk) begin
        if (reset)
            st <= IDLE;
        else
            st <= st_nxt;
    end

    // ---------------- FSM: next state
    always_comb begin
        st_nxt = st;
        case (st)
            IDLE: begin
                if (accept)
                    st_nxt = special ? DONE : RUN;
            end
            RUN: begin
                if (flush)
                    st_nxt = IDLE;
                else if (last)
                    st_nxt = DONE;
            end
            DONE:    st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs
    always_comb begin
        stall_req = ((st == IDLE) && accept) || (st == RUN);
        done      = (st == DONE);
    end

    assign result = result_q;

    // ---------------- datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            f3_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (st)
                IDLE: begin
                    if (accept) begin
                        f3_q  <= funct3;
                        hi_q  <= '0;
                        lo_q  <= is_div ? a_mag : b_mag;
                        m_q   <= is_div ? b_mag : a_mag;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        cnt_q <= '0;
                        if (special)
                            result_q <= special_res;
                    end
                end
                RUN: begin
                    if (!flush) begin
                        hi_q  <= hi_c[UNROLL];
                        lo_q  <= lo_c[UNROLL];
                        cnt_q <= cnt_q + CW'(1);
                        if (last)
                            result_q <= fin;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: a 32-bit/UNROLL=1 and a
// 64-bit/UNROLL=4 instance share one clock.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;

    logic        rst32, start32, flush32;
    logic [2:0]  f3_32;
    logic [31:0] a32, b32, r32;
    logic        stall32, done32;

    logic        rst64, start64, flush64;
    logic [2:0]  f3_64;
    logic [63:0] a64, b64, r64;
    logic        stall64, done64;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_muldiv_unit #(
        .XLEN(32), .UNROLL(1)
    ) u_dut32 (
        .clk(clk), .reset(rst32), .start(start32),
        .funct3(f3_32), .op_a(a32), .op_b(b32),
        .flush(flush32), .stall_req(stall32),
        .done(done32), .result(r32)
    );

    ex_muldiv_unit #(
        .XLEN(64), .UNROLL(4)
    ) u_dut64 (
        .clk(clk), .reset(rst64), .start(start64),
        .funct3(f3_64), .op_a(a64), .op_b(b64),
        .flush(flush64), .stall_req(stall64),
        .done(done64), .result(r64)
    );

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     tag, got, exp);
        end
    endtask

    // Issue one op, wait (bounded) for done, check latency,
    // stall cycles, result and that done is a single pulse.
    task automatic run_op(input bit w64, input string tag,
                          input logic [2:0] f,
                          input logic [63:0] a,
                          input logic [63:0] b,
                          input logic [63:0] exp,
                          input int lat);
        int cyc;
        int stalls;
        bit seen;
        logic [63:0] res;
        @(posedge clk); #1;
        if (w64) begin
            start64 = 1; f3_64 = f; a64 = a; b64 = b;
        end else begin
            start32 = 1; f3_32 = f;
            a32 = a[31:0]; b32 = b[31:0];
        end
        cyc = 0; stalls = 0; seen = 0; res = '0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            if (w64 ? stall64 : stall32) stalls++;
            if (w64 ? done64 : done32) begin
                seen = 1;
                res  = w64 ? r64 : {32'b0, r32};
            end else begin
                @(posedge clk); #1;
                start32 = 0; start64 = 0;
                cyc++;
            end
        end
        check({tag, " done"}, 64'(seen), 64'd1);
        check({tag, " latency"}, 64'(cyc), 64'(lat));
        check({tag, " stalls"}, 64'(stalls), 64'(lat));
        check({tag, " result"}, res, exp);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, " pulse"},
              64'(w64 ? done64 : done32), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0]  ra, rb;
        logic [127:0] p;
        int nd;

        rst32 = 1; start32 = 0; flush32 = 0;
        f3_32 = 0; a32 = 0; b32 = 0;
        rst64 = 1; start64 = 0; flush64 = 0;
        f3_64 = 0; a64 = 0; b64 = 0;
        repeat (2) @(posedge clk);
        #1;
        rst32 = 0; rst64 = 0;
        @(negedge clk);
        check("rst done32", 64'(done32), 0);
        check("rst res32", 64'(r32), 0);
        check("rst stall32", 64'(stall32), 0);
        check("rst done64", 64'(done64), 0);
        check("rst res64", r64, 0);

        // ---- 32-bit directed
        run_op(0, "mulh min*min", 3'b001,
               64'h8000_0000, 64'h8000_0000,
               64'h4000_0000, 33);
        run_op(0, "mul min*min", 3'b000,
               64'h8000_0000, 64'h8000_0000, 64'h0, 33);
        run_op(0, "mulhsu -1*2", 3'b010,
               64'hFFFF_FFFF, 64'h2, 64'hFFFF_FFFF, 33);
        run_op(0, "div -7/2", 3'b100,
               64'hFFFF_FFF9, 64'h2, 64'hFFFF_FFFD, 33);
        run_op(0, "rem -7/2", 3'b110,
               64'hFFFF_FFF9, 64'h2, 64'hFFFF_FFFF, 33);
        run_op(0, "divu 100/7", 3'b101,
               64'd100, 64'd7, 64'd14, 33);
        run_op(0, "remu 100/7", 3'b111,
               64'd100, 64'd7, 64'd2, 33);
        run_op(0, "divu x/0", 3'b101,
               64'h1234_5678, 64'h0, 64'hFFFF_FFFF, 1);
        run_op(0, "remu 7/0", 3'b111,
               64'd7, 64'h0, 64'd7, 1);
        run_op(0, "rem -5/0", 3'b110,
               64'hFFFF_FFFB, 64'h0, 64'hFFFF_FFFB, 1);
        run_op(0, "div ovf", 3'b100,
               64'h8000_0000, 64'hFFFF_FFFF,
               64'h8000_0000, 1);
        run_op(0, "rem ovf", 3'b110,
               64'h8000_0000, 64'hFFFF_FFFF, 64'h0, 1);
        run_op(0, "divu 100/7 b", 3'b101,
               64'd100, 64'd7, 64'd14, 33);

        // ---- flush in RUN: abort, result kept at 14
        @(posedge clk); #1;
        start32 = 1; f3_32 = 3'b011;
        a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF;
        nd = 0;
        for (int c = 0; c <= 10; c++) begin
            if (c == 10) flush32 = 1;
            @(negedge clk);
            if (done32) nd++;
            @(posedge clk); #1;
            start32 = 0;
        end
        flush32 = 0;
        @(negedge clk);
        check("flush no done", 64'(nd + int'(done32)), 0);
        check("flush idle", 64'(stall32), 0);
        check("flush result", 64'(r32), 64'd14);
        run_op(0, "mulhu after flush", 3'b011,
               64'hFFFF_FFFF, 64'hFFFF_FFFF,
               64'hFFFF_FFFE, 33);

        // ---- flush beats start in IDLE
        @(posedge clk); #1;
        start32 = 1; flush32 = 1; f3_32 = 3'b000;
        a32 = 32'd3; b32 = 32'd5;
        @(negedge clk);
        check("prio stall", 64'(stall32), 0);
        @(posedge clk); #1;
        start32 = 0; flush32 = 0;
        @(negedge clk);
        check("prio not run", 64'(stall32), 0);
        check("prio result", 64'(r32), 64'hFFFF_FFFE);

        // ---- 64-bit, UNROLL=4: directed
        run_op(1, "mulhu64 max", 3'b011, '1, '1,
               64'hFFFF_FFFF_FFFF_FFFE, 17);
        run_op(1, "mul64", 3'b000,
               64'h1_0000_0001, 64'h1_0000_0001,
               64'h0000_0002_0000_0001, 17);
        run_op(1, "mulh64 -1*2", 3'b001, '1, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFF, 17);
        run_op(1, "mulhsu64", 3'b010, '1, '1,
               64'hFFFF_FFFF_FFFF_FFFF, 17);
        run_op(1, "div64 -100/7", 3'b100,
               64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
               64'hFFFF_FFFF_FFFF_FFF2, 17);
        run_op(1, "rem64 -100/7", 3'b110,
               64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
               64'hFFFF_FFFF_FFFF_FFFE, 17);
        run_op(1, "divu64 big/3", 3'b101,
               64'h8000_0000_0000_0000, 64'd3,
               64'h2AAA_AAAA_AAAA_AAAA, 17);
        run_op(1, "div64 by 0", 3'b100,
               64'd9, 64'd0, '1, 1);

        // ---- 64-bit: pseudo-random vs arithmetic model
        for (int i = 0; i < 3; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom} | 64'd1;
            p = {64'b0, ra} * {64'b0, rb};
            run_op(1, "rnd mulhu", 3'b011, ra, rb,
                   p[127:64], 17);
            run_op(1, "rnd mul", 3'b000, ra, rb,
                   p[63:0], 17);
            p = {{64{ra[63]}}, ra} * {{64{rb[63]}}, rb};
            run_op(1, "rnd mulh", 3'b001, ra, rb,
                   p[127:64], 17);
            run_op(1, "rnd divu", 3'b101, ra, rb,
                   ra / rb, 17);
            run_op(1, "rnd remu", 3'b111, ra, rb,
                   ra % rb, 17);
            run_op(1, "rnd div", 3'b100, ra, rb,
                   64'($signed(ra) / $signed(rb)), 17);
        end
        run_op(1, "remu64 pre-rst", 3'b111,
               64'd100, 64'd7, 64'd2, 17);

        // ---- reset in the middle of RUN
        @(posedge clk); #1;
        start64 = 1; f3_64 = 3'b000;
        a64 = 64'h1234_5678_9ABC_DEF0; b64 = 64'd77;
        for (int c = 0; c <= 5; c++) begin
            if (c == 5) rst64 = 1;
            @(posedge clk); #1;
            start64 = 0;
        end
        rst64 = 0;
        @(negedge clk);
        check("rst64 done", 64'(done64), 0);
        check("rst64 result", r64, 0);
        check("rst64 idle", 64'(stall64), 0);
        run_op(1, "divu64 after rst", 3'b101,
               64'd100, 64'd7, 64'd14, 17);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
